cluster_bus_regulator: RTL
==========================

CLUSTER_BUS_REGULATOR -- requirements
Module: cluster_bus_regulator

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 8: the maximum combined outstanding AW+AR transactions.
REQ-002 SHALL have parameter PERIOD_W, default 16: the width of the regulation-period counter.
REQ-003 SHALL have parameter CREDIT_W, default 8: the width of the per-period transaction budget.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port en_i, input, 1: regulation enable; 0 means bypass.
REQ-007 SHALL have port period_i, input, PERIOD_W: the period length in cycles.
REQ-008 SHALL have port budget_i, input, CREDIT_W: the AX handshakes allowed per period.
REQ-009 SHALL have port max_outst_i, input, $clog2(MAX_OUTST+1): the runtime outstanding limit, clamped to MAX_OUTST.
REQ-010 SHALL have ports slv_aw_valid_i/slv_aw_ready_o and slv_ar_valid_i/slv_ar_ready_o, 1 each: the requester side.
REQ-011 SHALL have ports mst_aw_valid_o/mst_aw_ready_i and mst_ar_valid_o/mst_ar_ready_i, 1 each: the crossbar side.
REQ-012 SHALL have ports b_done_i and r_last_done_i, input, 1 each: B handshake and R handshake with last set, on the crossbar side.
REQ-013 SHALL have port outst_o, output, $clog2(MAX_OUTST+1): the current outstanding count.
REQ-014 SHALL have port err_o, output, 1: sticky underflow error.

Function
REQ-015 SHALL gate combinationally with zero latency: mst_x_valid_o = slv_x_valid_i & grant_x, and slv_x_ready_o = mst_x_ready_i & grant_x.
REQ-016 SHALL grant only when state is RUN, budget > 0 and outst < limit; when both AW and AR are valid and only one slot remains, SHALL grant by round-robin, with the winner's toggle updated on its handshake.
REQ-017 SHALL allow both AW and AR in the same cycle when there are at least 2 slots and a budget of at least 2.
REQ-018 SHALL have FSM states BYPASS, RUN and EXHAUSTED.
REQ-019 FSM transitions: BYPASS->RUN when en_i=1; RUN->EXHAUSTED when budget reaches 0; EXHAUSTED->RUN on refill; any state->BYPASS when en_i=0.
REQ-020 In BYPASS, SHALL grant unconditionally while still tracking outstanding count, and SHALL hold budget at budget_i.
REQ-021 SHALL run the period counter from period_i-1 down to 0, then refill budget to budget_i and reload on the next cycle; period_i=0 SHALL be treated as 1.
REQ-022 SHALL sample period_i/budget_i changes only at reload.
REQ-023 On refill and accept in the same cycle, SHALL compute budget = budget_i - accepted.
REQ-024 SHALL compute outst next = outst + accepted - completed (each term 0..2); simultaneous +1/-1 SHALL leave the count unchanged.
REQ-025 A completion at outst=0 SHALL saturate the count at 0 and set err_o.
REQ-026 Lowering max_outst_i below outst SHALL block new grants only, without dropping in-flight transactions.

Reset
REQ-027 On rst_ni=0 SHALL set state=BYPASS, outst_o=0, err_o=0, budget=0, period counter=0 and RR toggle=AW, which forces all grants to 0 until the first cycle after reset.
REQ-028 Reset mid-operation SHALL discard all counts; upstream must reset together.

Configuration
REQ-029 With CLUSTER_BUS_REGULATOR_STATS_EN defined, SHALL add port stall_cnt_o (32 bit): cycles where any slv valid=1 and grant=0, saturating, cleared by reset.
REQ-030 Without CLUSTER_BUS_REGULATOR_STATS_EN, SHALL have neither the port nor the logic.

Structure
REQ-031 SHALL place the state enum and the default MAX_OUTST/PERIOD_W/CREDIT_W values in pulp_cluster_package.
REQ-032 SHALL implement the period/budget logic in one sub-module, cluster_bus_reg_budget.
REQ-033 The outstanding counter and FSM SHALL stay in the top module.

Verification
REQ-034 Bench SHALL cover: en=0, 20 back-to-back AR with ready=1 -> all accepted, outst_o=20 mod clamp not exceeded, outst_o counts.
REQ-035 Bench SHALL cover: en=1, period=10, budget=3, continuous AW -> exactly 3 handshakes per 10 cycles, EXHAUSTED in between.
REQ-036 Bench SHALL cover: max_outst=2, AW+AR valid with outst=1 -> single grant alternating AW,AR,AW across releases.
REQ-037 Bench SHALL cover: AW handshake and b_done in the same cycle at outst=1 -> outst stays 1.
REQ-038 Bench SHALL cover: b_done at outst=0 -> err_o=1 and held, outst=0.
REQ-039 Bench SHALL cover: rst_ni pulse mid-burst with outst=5 -> outst_o=0, grants 0 during reset, BYPASS after.

Source files
------------

// File: rtl/pulp_cluster_package.sv
// Shared types and default sizing for the cluster bus regulator.
package pulp_cluster_package;

  typedef enum logic [1:0] {
    BYPASS    = 2'd0,
    RUN       = 2'd1,
    EXHAUSTED = 2'd2
  } bus_reg_state_e;

  localparam int unsigned BUS_REG_MAX_OUTST = 8;
  localparam int unsigned BUS_REG_PERIOD_W  = 16;
  localparam int unsigned BUS_REG_CREDIT_W  = 8;

endpackage

// File: rtl/cluster_bus_reg_budget.sv
// Regulation period counter and per-period AX handshake budget.
module cluster_bus_reg_budget
  import pulp_cluster_package::*;
#(
  parameter int unsigned PERIOD_W = BUS_REG_PERIOD_W,
  parameter int unsigned CREDIT_W = BUS_REG_CREDIT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                hold_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [CREDIT_W-1:0] budget_i,
  input  logic [1:0]          acc_i,
  output logic [CREDIT_W-1:0] budget_o,
  output logic [CREDIT_W-1:0] budget_nxt_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d, reload;
  logic [CREDIT_W-1:0] budget_q, budget_d;

  function automatic logic [CREDIT_W-1:0] sat_sub(input logic [CREDIT_W-1:0] a,
                                                   input logic [1:0]          b);
    logic [CREDIT_W:0] wide;
    wide = {1'b0, a} - (CREDIT_W+1)'(b);
    return wide[CREDIT_W] ? '0 : wide[CREDIT_W-1:0];
  endfunction

  // A zero period behaves as a one-cycle period.
  assign reload = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);

  always_comb begin
    cnt_d    = cnt_q;
    budget_d = budget_q;
    if (hold_i) begin
      cnt_d    = reload;
      budget_d = budget_i;
    end else if (cnt_q == '0) begin
      cnt_d    = reload;
      budget_d = sat_sub(budget_i, acc_i);
    end else begin
      cnt_d    = cnt_q - PERIOD_W'(1);
      budget_d = sat_sub(budget_q, acc_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      budget_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      budget_q <= budget_d;
    end
  end

  assign budget_o     = budget_q;
  assign budget_nxt_o = budget_d;

endmodule

// File: rtl/cluster_bus_regulator.sv
// AW/AR bandwidth and outstanding-transaction regulator in front of the cluster crossbar.
// Define CLUSTER_BUS_REGULATOR_STATS_EN to add the saturating stall counter port stall_cnt_o.
module cluster_bus_regulator
  import pulp_cluster_package::*;
#(
  parameter int unsigned MAX_OUTST = BUS_REG_MAX_OUTST,
  parameter int unsigned PERIOD_W  = BUS_REG_PERIOD_W,
  parameter int unsigned CREDIT_W  = BUS_REG_CREDIT_W
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [PERIOD_W-1:0]            period_i,
  input  logic [CREDIT_W-1:0]            budget_i,
  input  logic [$clog2(MAX_OUTST+1)-1:0] max_outst_i,
  input  logic                           slv_aw_valid_i,
  output logic                           slv_aw_ready_o,
  input  logic                           slv_ar_valid_i,
  output logic                           slv_ar_ready_o,
  output logic                           mst_aw_valid_o,
  input  logic                           mst_aw_ready_i,
  output logic                           mst_ar_valid_o,
  input  logic                           mst_ar_ready_i,
  input  logic                           b_done_i,
  input  logic                           r_last_done_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
  output logic                           err_o
`ifdef CLUSTER_BUS_REGULATOR_STATS_EN
  ,
  output logic [31:0]                    stall_cnt_o
`endif
);

  localparam int unsigned   OW      = $clog2(MAX_OUTST+1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTST);

  bus_reg_state_e      state_q, state_d;
  logic [OW-1:0]       outst_q, outst_d, limit, slots;
  logic [OW+1:0]       up_sum;
  logic                err_q, uflow;
  logic                rr_ar_q, contend;
  logic                grant_aw, grant_ar, aw_hs, ar_hs;
  logic                cap_one, cap_two;
  logic [1:0]          acc, comp;
  logic [CREDIT_W-1:0] budget, budget_nxt;

  function automatic logic [OW-1:0] clamp_outst(input logic [OW+1:0] v);
    return (v > (OW+2)'(MAX_OUTST)) ? MAX_CNT : v[OW-1:0];
  endfunction

  assign limit   = (max_outst_i > MAX_CNT) ? MAX_CNT : max_outst_i;
  assign slots   = (outst_q < limit) ? limit - outst_q : '0;
  assign cap_one = (slots != '0) && (budget != '0);
  assign cap_two = (slots > OW'(1)) && (budget > CREDIT_W'(1));

  // Grants are held low while reset is asserted, regardless of state.
  always_comb begin
    grant_aw = 1'b0;
    grant_ar = 1'b0;
    contend  = 1'b0;
    if (rst_ni) begin
      if (state_q == BYPASS) begin
        grant_aw = 1'b1;
        grant_ar = 1'b1;
      end else if (state_q == RUN && cap_one) begin
        if (slv_aw_valid_i && slv_ar_valid_i && !cap_two) begin
          contend  = 1'b1;
          grant_aw = !rr_ar_q;
          grant_ar = rr_ar_q;
        end else begin
          grant_aw = 1'b1;
          grant_ar = 1'b1;
        end
      end
    end
  end

  assign mst_aw_valid_o = slv_aw_valid_i & grant_aw;
  assign mst_ar_valid_o = slv_ar_valid_i & grant_ar;
  assign slv_aw_ready_o = mst_aw_ready_i & grant_aw;
  assign slv_ar_ready_o = mst_ar_ready_i & grant_ar;

  assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
  assign acc   = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign comp  = {1'b0, b_done_i} + {1'b0, r_last_done_i};

  // Completions beyond what is outstanding pin the count at zero and flag an error.
  assign up_sum  = (OW+2)'(outst_q) + (OW+2)'(acc);
  assign uflow   = up_sum < (OW+2)'(comp);
  assign outst_d = uflow ? '0 : clamp_outst(up_sum - (OW+2)'(comp));

  cluster_bus_reg_budget #(
    .PERIOD_W (PERIOD_W),
    .CREDIT_W (CREDIT_W)
  ) i_budget (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .hold_i       (state_q == BYPASS),
    .period_i     (period_i),
    .budget_i     (budget_i),
    .acc_i        (acc),
    .budget_o     (budget),
    .budget_nxt_o (budget_nxt)
  );

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = BYPASS;
    end else begin
      case (state_q)
        BYPASS:    state_d = RUN;
        RUN:       if (budget_nxt == '0) state_d = EXHAUSTED;
        EXHAUSTED: if (budget_nxt != '0) state_d = RUN;
        default:   state_d = BYPASS;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BYPASS;
      outst_q <= '0;
      err_q   <= 1'b0;
      rr_ar_q <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      err_q   <= err_q | uflow;
      if (contend && aw_hs)      rr_ar_q <= 1'b1;
      else if (contend && ar_hs) rr_ar_q <= 1'b0;
    end
  end

  assign outst_o = outst_q;
  assign err_o   = err_q;

`ifdef CLUSTER_BUS_REGULATOR_STATS_EN
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (slv_aw_valid_i & !grant_aw) | (slv_ar_valid_i & !grant_ar);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      stall_q <= '0;
    else if (stall && stall_q != '1)  stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
